// File: rtl/wb_single_master_if.sv
// ---------------------------------------------------------------------------
// wb_single_master_if
//   Wishbone classic-pipelined bus bundle between a single master and its
//   slave/interconnect. Signal names keep the master's point of view
//   (_o = driven by the master, _i = driven by the slave).
//
//   master modport : drives cyc/stb/we/adr/sel/dat_o, samples dat_i/ack/err/rty/stall
//   slave  modport : the mirror image
// ---------------------------------------------------------------------------
interface wb_single_master_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_o;
  logic [31:0]           wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;

  modport master (
    output wb_cyc_o,
    output wb_stb_o,
    output wb_we_o,
    output wb_adr_o,
    output wb_sel_o,
    output wb_dat_o,
    input  wb_dat_i,
    input  wb_ack_i,
    input  wb_err_i,
    input  wb_rty_i,
    input  wb_stall_i
  );

  modport slave (
    input  wb_cyc_o,
    input  wb_stb_o,
    input  wb_we_o,
    input  wb_adr_o,
    input  wb_sel_o,
    input  wb_dat_o,
    output wb_dat_i,
    output wb_ack_i,
    output wb_err_i,
    output wb_rty_i,
    output wb_stall_i
  );

endinterface

// File: rtl/wb_single_master.sv
// ---------------------------------------------------------------------------
// wb_single_master
//   Turns a one-shot host request into exactly one Wishbone classic-pipelined
//   transaction, with stall handling, err/rty/ack responses, bounded retry
//   and a per-attempt response timeout. One transaction outstanding at most.
//
// Parameters
//   ADDR_WIDTH : host / WB byte address width
//   TIMEOUT    : cycles per attempt (from first stb cycle) before abort, >= 2
//   MAX_RETRY  : rty responses tolerated before giving up (0 = no retry)
//
// Ports
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   req_i               : start request, only looked at while idle
//   we_i/adr_i/dat_i/sel_i : request fields, latched together with req_i
//   busy_o              : transaction in progress
//   done_o              : one-cycle completion pulse
//   status_o            : 00 ok, 01 err, 10 retry exhausted, 11 timeout
//   rdata_o             : read data from the most recent read ack
//   wb                  : Wishbone master modport
// ---------------------------------------------------------------------------
module wb_single_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [31:0]           dat_i,
  input  logic [3:0]            sel_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            status_o,
  output logic [31:0]           rdata_o,
  wb_single_master_if.master    wb
);

  // Timeout counter never needs to hold more than TIMEOUT-1; keep at least 8 bits.
  localparam int TW = (TIMEOUT > 256) ? $clog2(TIMEOUT) : 8;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  localparam logic [1:0] STAT_OK  = 2'b00;
  localparam logic [1:0] STAT_ERR = 2'b01;
  localparam logic [1:0] STAT_RTY = 2'b10;
  localparam logic [1:0] STAT_TMO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_BACKOFF = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic                  we_q,  we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic [3:0]            sel_q, sel_d;

  // Attempt bookkeeping
  logic [RW-1:0]         retry_q, retry_d;
  logic [TW-1:0]         tmo_q,   tmo_d;

  // Registered outputs
  logic                  cyc_q,    cyc_d;
  logic                  stb_q,    stb_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic [1:0]            status_q, status_d;
  logic [31:0]           rdata_q,  rdata_d;

  // Decisions taken by the next-state logic
  logic                  fin_s;
  logic [1:0]            fin_code_s;
  logic                  latch_s;
  logic                  retry_s;
  logic                  rd_capture_s;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: responses are only meaningful in REQ/WAIT (cyc=1);
  // err beats rty beats ack, and any response beats the timeout.
  always_comb begin
    state_d      = state_q;
    fin_s        = 1'b0;
    fin_code_s   = STAT_OK;
    latch_s      = 1'b0;
    retry_s      = 1'b0;
    rd_capture_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = S_REQ;
          latch_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ, S_WAIT: begin
        if (wb.wb_err_i) begin
          state_d    = S_IDLE;
          fin_s      = 1'b1;
          fin_code_s = STAT_ERR;
        end else if (wb.wb_rty_i) begin
          if (retry_q != RTY_MAX) begin
            state_d = S_BACKOFF;
            retry_s = 1'b1;
          end else begin
            state_d    = S_IDLE;
            fin_s      = 1'b1;
            fin_code_s = STAT_RTY;
          end
        end else if (wb.wb_ack_i) begin
          state_d      = S_IDLE;
          fin_s        = 1'b1;
          fin_code_s   = STAT_OK;
          rd_capture_s = ~we_q;
        end else if (tmo_q == TMO_LAST) begin
          state_d    = S_IDLE;
          fin_s      = 1'b1;
          fin_code_s = STAT_TMO;
        end else if ((state_q == S_REQ) && !wb.wb_stall_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      S_BACKOFF: begin
        state_d = S_REQ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request latch, retry counter and per-attempt timeout counter
  always_comb begin
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    retry_d = retry_q;
    tmo_d   = {TW{1'b0}};
    if (latch_s) begin
      we_d    = we_i;
      adr_d   = adr_i;
      dat_d   = dat_i;
      sel_d   = sel_i;
      retry_d = {RW{1'b0}};
    end else if (retry_s) begin
      retry_d = retry_q + RW'(1'b1);
    end else begin
      retry_d = retry_q;
    end
    // Counter runs only while staying inside one attempt; entering REQ clears it.
    if (((state_q == S_REQ) || (state_q == S_WAIT)) &&
        ((state_d == S_REQ) || (state_d == S_WAIT))) begin
      tmo_d = tmo_q + TW'(1'b1);
    end else begin
      tmo_d = {TW{1'b0}};
    end
  end

  // Output decode: next values of the registered outputs follow state_d
  always_comb begin
    cyc_d  = (state_d == S_REQ) || (state_d == S_WAIT);
    stb_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = fin_s;
    if (fin_s) begin
      status_d = fin_code_s;
    end else begin
      status_d = status_q;
    end
    if (rd_capture_s) begin
      rdata_d = wb.wb_dat_i;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      adr_q    <= {ADDR_WIDTH{1'b0}};
      dat_q    <= 32'h0000_0000;
      sel_q    <= 4'h0;
      retry_q  <= {RW{1'b0}};
      tmo_q    <= {TW{1'b0}};
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 2'b00;
      rdata_q  <= 32'h0000_0000;
    end else begin
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign rdata_o     = rdata_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_single_master.sv
// ---------------------------------------------------------------------------
// tb_wb_single_master
//   Transactions are planned up front: for each one the bench picks stall
//   lengths, response delay and response type per attempt, and a timeline
//   model derives the expected per-cycle outputs from the protocol rules.
//   The slave side is then replayed open-loop and every cycle is compared.
// ---------------------------------------------------------------------------
module tb_wb_single_master;

  localparam int AW  = 8;
  localparam int TMO = 16;
  localparam int MR  = 3;
  localparam int NC  = 32768;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i;
  logic [7:0]  adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        busy_o, done_o;
  logic [1:0]  status_o;
  logic [31:0] rdata_o;

  wb_single_master_if #(.ADDR_WIDTH(AW)) bus ();

  wb_single_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .sel_i(sel_i), .busy_o(busy_o), .done_o(done_o),
    .status_o(status_o), .rdata_o(rdata_o), .wb(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic req; logic we; logic [7:0] adr; logic [31:0] dat; logic [3:0] sel;
    logic ack; logic err; logic rty; logic stall; logic [31:0] rdat;
  } drv_t;

  typedef struct packed {
    logic cyc; logic stb; logic busy; logic done; logic [1:0] status;
    logic [31:0] rdata; logic we; logic [7:0] adr; logic [31:0] dat; logic [3:0] sel;
  } exp_t;

  drv_t drv  [NC];
  exp_t expv [NC];

  int n_cmp = 0;
  int n_bad = 0;
  int cur_n = 0;
  bit run_en = 1'b0;

  // model state: what the block must currently be holding
  logic        m_we;
  logic [7:0]  m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic [1:0]  m_status;
  logic [31:0] m_rdata;
  int          m_free = 0;
  int          m_next = 0;

  // per-attempt plan: stall count, response delay from first stb (-1 none), {err,rty,ack}, read data
  int          p_k [4];
  int          p_r [4];
  logic [2:0]  p_t [4];
  logic [31:0] p_d [4];

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, want);
    end
  endtask

  function automatic exp_t mk(input logic cyc, input logic stb, input logic busy, input logic done);
    exp_t x;
    x.cyc = cyc; x.stb = stb; x.busy = busy; x.done = done;
    x.status = m_status; x.rdata = m_rdata;
    x.we = m_we; x.adr = m_adr; x.dat = m_dat; x.sel = m_sel;
    return x;
  endfunction

  task automatic fill_idle(input int upto);
    for (int c = m_next; c <= upto; c++) expv[c] = mk(1'b0, 1'b0, 1'b0, 1'b0);
    if (upto + 1 > m_next) m_next = upto + 1;
  endtask

  task automatic set_plan(input int a, input int k, input int r, input logic [2:0] t, input logic [31:0] d);
    p_k[a] = k; p_r[a] = r; p_t[a] = t; p_d[a] = d;
  endtask

  // Timeline model of one transaction starting with req_i in cycle t0.
  task automatic run_txn(input int gap, input logic we, input logic [7:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         output int t0, output int td);
    int s, e, a;
    bit fin, hit;
    t0 = m_free + gap;
    fill_idle(t0);
    drv[t0].req = 1'b1; drv[t0].we = we; drv[t0].adr = adr;
    drv[t0].dat = dat;  drv[t0].sel = sel;
    m_we = we; m_adr = adr; m_dat = dat; m_sel = sel;
    s = t0 + 1; a = 0; fin = 1'b0; e = s;
    while (!fin) begin
      hit = (p_r[a] >= 0) && (p_r[a] <= TMO - 1);
      e = hit ? s + p_r[a] : s + TMO - 1;
      for (int c = s; c <= e; c++) begin
        expv[c] = mk(1'b1, (c <= s + p_k[a]), 1'b1, 1'b0);
        drv[c].req = 1'($urandom_range(0, 1));
        drv[c].ack = 1'b0; drv[c].err = 1'b0; drv[c].rty = 1'b0;
        if (c <= s + p_k[a]) drv[c].stall = (c < s + p_k[a]);
      end
      if (hit) begin
        {drv[e].err, drv[e].rty, drv[e].ack} = p_t[a];
        drv[e].rdat = p_d[a];
      end
      if (hit && p_t[a][2]) begin
        m_status = 2'b01; fin = 1'b1;
      end else if (hit && p_t[a][1]) begin
        if (a < MR) begin
          expv[e + 1] = mk(1'b0, 1'b0, 1'b1, 1'b0);
          drv[e + 1].req = 1'($urandom_range(0, 1));
          s = e + 2; a++;
        end else begin
          m_status = 2'b10; fin = 1'b1;
        end
      end else if (hit) begin
        m_status = 2'b00;
        if (!we) m_rdata = p_d[a];
        fin = 1'b1;
      end else begin
        m_status = 2'b11; fin = 1'b1;
      end
    end
    td = e + 1;
    expv[td] = mk(1'b0, 1'b0, 1'b0, 1'b1);
    m_free = td;
    m_next = td + 1;
  endtask

  task automatic apply(input int n);
    req_i = drv[n].req; we_i = drv[n].we; adr_i = drv[n].adr;
    dat_i = drv[n].dat; sel_i = drv[n].sel;
    bus.wb_ack_i = drv[n].ack; bus.wb_err_i = drv[n].err; bus.wb_rty_i = drv[n].rty;
    bus.wb_stall_i = drv[n].stall; bus.wb_dat_i = drv[n].rdat;
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin : cmp_p
    exp_t x;
    if (run_en) begin
      x = expv[cur_n];
      chk("busy",   cur_n, 32'(busy_o),       32'(x.busy));
      chk("done",   cur_n, 32'(done_o),       32'(x.done));
      chk("cyc",    cur_n, 32'(bus.wb_cyc_o), 32'(x.cyc));
      chk("stb",    cur_n, 32'(bus.wb_stb_o), 32'(x.stb));
      chk("status", cur_n, 32'(status_o),     32'(x.status));
      chk("rdata",  cur_n, rdata_o,           x.rdata);
      chk("wb_we",  cur_n, 32'(bus.wb_we_o),  32'(x.we));
      chk("wb_adr", cur_n, 32'(bus.wb_adr_o), 32'(x.adr));
      chk("wb_dat", cur_n, bus.wb_dat_o,      x.dat);
      chk("wb_sel", cur_n, 32'(bus.wb_sel_o), 32'(x.sel));
    end
  end

  initial begin
    int t0, td, last, v;
    rst = 1'b1;
    m_we = 1'b0; m_adr = 8'h00; m_dat = 32'h0; m_sel = 4'h0;
    m_status = 2'b00; m_rdata = 32'h0;
    for (int c = 0; c < NC; c++) begin
      drv[c].req = 1'b0; drv[c].we = 1'($urandom_range(0, 1));
      drv[c].adr = 8'($urandom); drv[c].dat = $urandom; drv[c].sel = 4'($urandom);
      drv[c].ack = ($urandom_range(0, 3) == 0); drv[c].err = ($urandom_range(0, 3) == 0);
      drv[c].rty = ($urandom_range(0, 3) == 0); drv[c].stall = 1'($urandom_range(0, 1));
      drv[c].rdat = $urandom;
    end
    apply(0);

    // 1: write, ack one cycle after stb
    set_plan(0, 0, 1, 3'b001, 32'hDEAD0001);
    run_txn(2, 1'b1, 8'h00, 32'h000007F0, 4'hF, t0, td);
    chk("t1_latency", 0, 32'(td - t0), 32'd3);
    chk("t1_status",  0, 32'(m_status), 32'd0);
    // 2: read, 3 stall cycles, then ack with 0x212 (issued back-to-back)
    set_plan(0, 3, 4, 3'b001, 32'h00000212);
    run_txn(0, 1'b0, 8'h3C, 32'h11111111, 4'h3, t0, td);
    chk("t2_latency", 0, 32'(td - t0), 32'd6);
    chk("t2_rdata",   0, m_rdata, 32'h00000212);
    // 3: read err, then ack+err together
    set_plan(0, 0, 1, 3'b100, 32'hBAD00001);
    run_txn(1, 1'b0, 8'h44, 32'h0, 4'hF, t0, td);
    chk("t3a_status", 0, 32'(m_status), 32'd1);
    chk("t3a_rdata",  0, m_rdata, 32'h00000212);
    set_plan(0, 0, 1, 3'b101, 32'hBAD00002);
    run_txn(0, 1'b0, 8'h45, 32'h0, 4'hF, t0, td);
    chk("t3b_status", 0, 32'(m_status), 32'd1);
    chk("t3b_rdata",  0, m_rdata, 32'h00000212);
    // 4: always rty -> exhausted; rty,rty,ack -> ok
    for (int a = 0; a < 4; a++) set_plan(a, 0, 1, 3'b010, 32'h0);
    run_txn(1, 1'b1, 8'h80, 32'hCAFEF00D, 4'h5, t0, td);
    chk("t4a_span",   0, 32'(td - t0), 32'd12);
    chk("t4a_status", 0, 32'(m_status), 32'd2);
    set_plan(0, 0, 1, 3'b010, 32'h0);
    set_plan(1, 0, 1, 3'b010, 32'h0);
    set_plan(2, 0, 1, 3'b001, 32'h0000ABCD);
    run_txn(1, 1'b0, 8'h81, 32'h0, 4'hF, t0, td);
    chk("t4b_span",   0, 32'(td - t0), 32'd9);
    chk("t4b_status", 0, 32'(m_status), 32'd0);
    chk("t4b_rdata",  0, m_rdata, 32'h0000ABCD);
    // 5: no response -> timeout; ack on the last counted cycle -> ok
    set_plan(0, 0, -1, 3'b000, 32'h0);
    run_txn(1, 1'b0, 8'h90, 32'h0, 4'hF, t0, td);
    chk("t5a_span",   0, 32'(td - t0), 32'd17);
    chk("t5a_status", 0, 32'(m_status), 32'd3);
    set_plan(0, 0, 15, 3'b001, 32'h5A5A5A5A);
    run_txn(0, 1'b0, 8'h91, 32'h0, 4'hF, t0, td);
    chk("t5b_span",   0, 32'(td - t0), 32'd17);
    chk("t5b_status", 0, 32'(m_status), 32'd0);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      if (m_free < NC - 400) begin
        for (int a = 0; a < 4; a++) begin
          p_k[a] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
          case ($urandom_range(0, 7))
            0:       p_r[a] = -1;
            1:       p_r[a] = int'($urandom_range(12, 18));
            default: p_r[a] = int'($urandom_range(0, p_k[a] + 3));
          endcase
          v = int'($urandom_range(0, 9));
          if (v < 5)      p_t[a] = 3'b001;
          else if (v < 7) p_t[a] = 3'b010;
          else if (v < 8) p_t[a] = 3'b100;
          else            p_t[a] = 3'($urandom_range(1, 7));
          p_d[a] = $urandom;
        end
        run_txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
                $urandom, 4'($urandom), t0, td);
      end
    end
    last = m_free + 3;
    fill_idle(last);

    #22 rst = 1'b0;
    for (int n = 0; n <= last; n++) begin
      @(posedge clk);
      #1;
      cur_n = n;
      apply(n);
      run_en = 1'b1;
    end
    @(negedge clk);
    #1 run_en = 1'b0;

    // 6: reset in the middle of WAIT
    req_i = 1'b0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
    bus.wb_stall_i = 1'b0;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; adr_i = 8'h5A; sel_i = 4'hF;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_cyc",  0, 32'(bus.wb_cyc_o), 32'd1);
    chk("rst_pre_busy", 0, 32'(busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_cyc",    0, 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb",    0, 32'(bus.wb_stb_o), 32'd0);
    chk("rst_busy",   0, 32'(busy_o), 32'd0);
    chk("rst_done",   0, 32'(done_o), 32'd0);
    chk("rst_status", 0, 32'(status_o), 32'd0);
    chk("rst_rdata",  0, rdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.wb_ack_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_after_done", i, 32'(done_o), 32'd0);
      chk("rst_after_busy", i, 32'(busy_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
